// File: rtl/fir_input_stimulus.sv
// -----------------------------------------------------------------------------
// fir_input_stimulus
//
// Plays a fixed table of signed samples into a downstream consumer (the FIR
// under test) over a valid/ready handshake, one table entry per accepted
// transfer. With LOOP=0 the table is played once and the block parks in DONE
// with a sticky done flag. With LOOP=1 it wraps from the last entry to entry 0
// with no bubble and keeps going.
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1.
// While valid=1 and ready=0, data and index are held stable until accepted.
// valid never drops without a transfer, except on abort or reset.
//
// Parameters:
//   DEPTH  number of table entries (>= 2)
//   WIDTH  sample width, signed two's complement
//   LOOP   0: stop after last entry, 1: wrap to entry 0 and continue
//   TABLE  sample constants, entry 0 in the least significant slot
//
// Ports:
//   system1000       in   clock, rising edge
//   system1000_rstn  in   asynchronous reset, active HIGH despite the name
//   start            in   request playback (IDLE or DONE only)
//   abort            in   synchronous stop back to IDLE, beats start/ready
//   ready            in   downstream accepts data this cycle
//   data             out  current sample (registered)
//   valid            out  data is offered (registered)
//   index            out  table index of data (registered)
//   done             out  sticky end-of-sequence flag (registered)
// -----------------------------------------------------------------------------
module fir_input_stimulus #(
   parameter int                          DEPTH = 4,
   parameter int                          WIDTH = 16,
   parameter int                          LOOP  = 0,
   parameter logic [DEPTH-1:0][WIDTH-1:0] TABLE = {16'h0008, 16'hFFFE,
                                                   16'h0003, 16'h0002}
) (
   input  logic                           system1000,
   input  logic                           system1000_rstn,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           ready,
   output logic signed [WIDTH-1:0]        data,
   output logic                           valid,
   output logic [$clog2(DEPTH)-1:0]       index,
   output logic                           done
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // State is kept as a named enum so checkers can bind to state_q directly.
   state_t                  state_q;
   logic signed [WIDTH-1:0] data_q;
   logic                    valid_q;
   logic [IW-1:0]           index_q;
   logic                    done_q;

   // Next table position; only used when index_q < LAST_IDX, so it never
   // leaves the table even for non-power-of-two DEPTH.
   logic [IW-1:0]           idx_inc_d;
   logic                    is_last_d;

   always_comb begin
      idx_inc_d = index_q + IW'(1);
      is_last_d = (index_q == LAST_IDX);
   end

   function automatic logic [WIDTH-1:0] tbl(input logic [IW-1:0] i);
      return TABLE[i];
   endfunction

   always_ff @(posedge system1000 or posedge system1000_rstn) begin
      if (system1000_rstn) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         index_q <= '0;
         done_q  <= 1'b0;
      end else if (abort) begin
         // Abort discards everything, even when it lands on the final
         // transfer edge; that last sample still counts as delivered.
         state_q <= S_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         index_q <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_RUN;
                  data_q  <= tbl('0);
                  valid_q <= 1'b1;
                  index_q <= '0;
                  done_q  <= 1'b0;
               end
            end
            S_RUN: begin
               // valid_q is always 1 in RUN, so ready alone marks a transfer.
               if (ready) begin
                  if (!is_last_d) begin
                     index_q <= idx_inc_d;
                     data_q  <= tbl(idx_inc_d);
                  end else if (LOOP != 0) begin
                     index_q <= '0;
                     data_q  <= tbl('0);
                  end else begin
                     // data/index keep the last delivered entry.
                     state_q <= S_DONE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               data_q  <= '0;
               valid_q <= 1'b0;
               index_q <= '0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign index = index_q;
   assign done  = done_q;

`ifndef SYNTHESIS
   // An offered sample must not change or be withdrawn until accepted.
   a_hold_stable: assert property (
      @(posedge system1000) disable iff (system1000_rstn)
         (valid_q && !ready && !abort) |=> (valid_q && $stable(data_q) && $stable(index_q))
   );

   // done and valid are mutually exclusive.
   a_done_not_valid: assert property (
      @(posedge system1000) disable iff (system1000_rstn)
         done_q |-> !valid_q
   );

   // Index never leaves the table.
   a_index_range: assert property (
      @(posedge system1000) disable iff (system1000_rstn)
         index_q <= LAST_IDX
   );
`endif

endmodule

// File: doc/fir_input_stimulus.md
# fir_input_stimulus

Stimulus source for the FIR testbench. Plays a fixed table of signed samples into the FIR under test over a valid/ready handshake, one sample per accepted transfer. It runs on the same clock domain as the output checker and is the driving counterpart to it. The block is synthesizable apart from its constant table, and is intended to sit between reset/sequencing logic and the FIR `i` input.

## Interface
Parameters:
- `DEPTH`, 4: number of table entries; must be ≥ 2.
- `WIDTH`, 16: sample width, signed two's complement.
- `LOOP`, 0: 0 stops after the last entry; 1 wraps to entry 0 and continues.
- `TABLE`, {2, 3, -2, 8}: sample constants, entry 0 first, each `WIDTH` bits signed.

Ports:
- `system1000`, input, 1: clock; all state updates on the rising edge.
- `system1000_rstn`, input, 1: reset, asynchronous, active-high. Asserting it forces the reset state immediately. The port name follows the domain naming; polarity is high.
- `start`, input, 1: request playback; sampled on the rising edge.
- `abort`, input, 1: synchronous stop; returns the block to IDLE.
- `ready`, input, 1: downstream accepts `data` this cycle.
- `data`, output, `WIDTH` signed: current sample (registered).
- `valid`, output, 1: `data` is offered (registered).
- `index`, output, clog2(`DEPTH`): table index of `data` (registered).
- `done`, output, 1: the non-loop sequence has completed (registered, sticky).

## Operation
- States are IDLE, RUN and DONE. Reset state is IDLE with `data`=0, `valid`=0, `index`=0, `done`=0.
- **IDLE**:
  - If `start`=1: go to RUN; `valid`←1, `index`←0, `data`←TABLE[0].
  - Otherwise all outputs hold.
- **RUN**:
  - A transfer occurs on any edge where `valid`=1 and `ready`=1.
  - No transfer (`ready`=0): `data` and `index` hold, and `valid` stays 1. The offered data must stay stable until it is accepted.
  - Transfer with `index` < `DEPTH`-1: `index`←`index`+1, `data`←TABLE[`index`+1], `valid` stays 1.
  - Transfer with `index` = `DEPTH`-1 and `LOOP`=1: `index`←0, `data`←TABLE[0]. There is no bubble.
  - Transfer with `index` = `DEPTH`-1 and `LOOP`=0: go to DONE; `valid`←0, `done`←1. `data` and `index` hold their last values.
  - `start` is ignored in RUN.
- **DONE**:
  - `done` stays 1 and `valid` stays 0.
  - `start`=1 restarts exactly as from IDLE (`done`←0, `valid`←1, `index`←0, `data`←TABLE[0]).
- **abort**:
  - Takes effect in any state and has priority over `start` and `ready`.
  - Next state is IDLE; `valid`←0, `done`←0, `index`←0, `data`←0.
  - An abort on the same edge as the final transfer still discards state. The final sample itself counts as delivered.
- **Index arithmetic**:
  - `index` is unsigned and compared against the constant `DEPTH`-1 at full width.
  - The increment never exceeds `DEPTH`-1, so non-power-of-two `DEPTH` is supported.
  - `data` is a direct table lookup with no sign changes or truncation.

## Timing
- Latency from the `start` edge to the first `valid`=1 is 1 cycle (visible after that edge).
- Throughput is one sample per cycle while `ready`=1; with `LOOP`=1 this rate is sustained indefinitely.
- `done` rises on the edge that accepts entry `DEPTH`-1. With `ready` held high this is `DEPTH` edges after the first `valid`.
- Reset asserted mid-RUN drops `valid` immediately and asynchronously. After reset is released, the block stays in IDLE until the next `start`.
- There is no combinational path from input to output; all four outputs come straight from flops.

## Test plan
- Reset then `start` pulse with `ready`=1 held and default parameters → `data` shows 2, 3, -2, 8 on consecutive cycles with `index` 0..3. `valid` falls and `done`=1 on the 4th accept edge, then both stay put.
- Same run with `ready` toggling 1,0,0,1,0,1,1 → each sample is held stable while `ready`=0. The same 4 values are delivered in order with no duplicates or skips, and `done` rises only after the 4th accept.
- `LOOP`=1 with `ready`=1 for 10 cycles → `data` = 2,3,-2,8,2,3,-2,8,2,3. `index` wraps 3→0 without a bubble and `done` stays 0.
- `abort` pulsed while `index`=2 with `ready`=1 → the next edge gives `valid`=0, `index`=0, `data`=0. A later `start` replays from 2.
- Reset asserted asynchronously mid-RUN, between edges → `valid`, `data`, `index` and `done` go to 0 before the next edge. A `start` held during reset has no effect until reset is released.
- In DONE, `start` and `abort` on the same edge → IDLE with all outputs 0, and `start` is ignored. A `start` on the next cycle → `valid`=1, `data`=2, `done`=0.
